// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: captures a binary value, converts it to
// decimal (sequential double-dabble) or hex digits, and scans them out one digit per slot.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [6:0]            display,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_start_conv;
    logic                 w_commit_hex;
    logic                 w_commit_dec;
    logic                 w_commit;

    logic [BIN_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     w_bcd_step;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_conv_blz;
    logic                 r_conv_ovf;

    logic                 w_dec_ovf;
    logic                 w_hex_ovf;
    logic [BCD_W-1:0]     w_nib;
    logic                 w_ovf;
    logic                 w_blz;
    logic [6:0]           w_code [NUM_DIGITS];
    logic [6:0]           r_seg  [NUM_DIGITS];

    logic [PRE_W-1:0]     r_presc;
    logic [IDX_W-1:0]     r_idx;
    logic [6:0]           r_display;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                 r_busy;
    logic                 r_overflow;

    assign display  = r_display;
    assign digit_en = r_digit_en;
    assign busy     = r_busy;
    assign overflow = r_overflow;

    assign w_dec_ovf = 64'(value) > DEC_MAX;
    assign w_hex_ovf = (64'(value) >> BCD_W) != 64'd0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: loads are only honoured when idle
    always_comb begin
        w_state_nxt  = r_state;
        w_start_conv = 1'b0;
        w_commit_hex = 1'b0;
        w_commit_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    if (hex_mode) begin
                        w_commit_hex = 1'b1;
                    end else begin
                        w_start_conv = 1'b1;
                        w_state_nxt  = S_CONV;
                    end
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                    w_commit_dec = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift in the next bit
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_step = {w_bcd_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
    end

    assign w_commit = w_commit_hex | w_commit_dec;
    assign w_nib    = w_commit_hex ? BCD_W'(value) : w_bcd_step;
    assign w_ovf    = w_commit_hex ? w_hex_ovf : r_conv_ovf;
    assign w_blz    = w_commit_hex ? blank_lz  : r_conv_blz;

    // Segment codes for the committed digits, walking down from the top to find leading zeros
    always_comb begin
        logic v_lead;
        v_lead = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) w_code[i] = SEG_BLANK;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            v_lead = v_lead && (w_nib[4*i +: 4] == 4'd0);
            if (w_ovf)                       w_code[i] = SEG_DASH;
            else if (w_blz && v_lead && i != 0) w_code[i] = SEG_BLANK;
            else                             w_code[i] = seg_of(w_nib[4*i +: 4]);
        end
    end

    // Conversion datapath and digit register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_conv_blz <= 1'b0;
            r_conv_ovf <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) r_seg[i] <= SEG_BLANK;
        end else begin
            r_busy <= (w_state_nxt == S_CONV);
            if (w_start_conv) begin
                r_shift    <= value;
                r_bcd      <= '0;
                r_cnt      <= '0;
                r_conv_blz <= blank_lz;
                r_conv_ovf <= w_dec_ovf;
            end else if (r_state == S_CONV) begin
                r_shift <= r_shift << 1;
                r_bcd   <= w_bcd_step;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_seg      <= w_code;
                r_overflow <= w_ovf;
            end
        end
    end

    // Free-running scan; display and enable are registered together so they never skew
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_display  <= SEG_BLANK;
            r_digit_en <= '1;
        end else begin
            if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
            r_display  <= r_seg[r_idx];
            r_digit_en <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads/resets,
// every cycle compared against an arithmetic model of the displayed digits.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int SD = 4;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] value;
    logic          load;
    logic          hex_mode;
    logic          blank_lz;
    logic [6:0]    display;
    logic [ND-1:0] digit_en;
    logic          busy;
    logic          overflow;

    seg7_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .display(display),
        .digit_en(digit_en), .busy(busy), .overflow(overflow));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what each digit should show, the overflow flag, and a conversion timer
    logic [6:0] m_dreg [ND];
    logic       m_ovf;
    int         m_cnt;
    int         since;
    int         p_val;
    bit         p_blz;
    logic [6:0] e_disp;
    logic [3:0] e_den;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input int v, input bit hx, input bit blz);
        int lim;
        int p;
        bit ov;
        lim = 1;
        for (int i = 0; i < ND; i++) lim = lim * 10;
        ov = hx ? ((v >> (4 * ND)) != 0) : (v > lim - 1);
        p = 1;
        for (int i = 0; i < ND; i++) begin
            int q;
            int d;
            q = hx ? (v >> (4 * i)) : (v / p);
            d = hx ? (q % 16) : (q % 10);
            if (ov)                         m_dreg[i] = 7'b0111111;
            else if (blz && i > 0 && q == 0) m_dreg[i] = 7'b1111111;
            else                            m_dreg[i] = SEG[d];
            p = p * 10;
        end
        m_ovf = ov;
    endtask

    task automatic tick();
        bit rst_s, ld_s, hx_s, blz_s;
        int v_s;
        rst_s = reset; ld_s = load; hx_s = hex_mode; blz_s = blank_lz; v_s = int'(value);
        @(posedge clk);
        if (rst_s) begin
            since = 0;
            for (int i = 0; i < ND; i++) m_dreg[i] = 7'b1111111;
            m_ovf  = 1'b0;
            m_cnt  = 0;
            e_disp = 7'b1111111;
            e_den  = 4'b1111;
        end else begin
            int k;
            int idx;
            k = since;
            since++;
            idx    = (k / SD) % ND;
            e_disp = m_dreg[idx];
            e_den  = ~(4'b0001 << idx);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) commit(p_val, 1'b0, p_blz);
            end else if (ld_s) begin
                if (hx_s) commit(v_s, 1'b1, blz_s);
                else begin
                    m_cnt = BW;
                    p_val = v_s;
                    p_blz = blz_s;
                end
            end
        end
        #1;
        chk("display",  32'(display),  32'(e_disp));
        chk("digit_en", 32'(digit_en), 32'(e_den));
        chk("busy",     32'(busy),     32'(m_cnt > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input int v, input bit hx, input bit blz);
        value = BW'(v); hex_mode = hx; blank_lz = blz; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Record the code shown for each digit over one full scan
    task automatic capture(output logic [6:0] seen [ND]);
        for (int j = 0; j < ND; j++) seen[j] = 7'bx;
        repeat (SD * ND) begin
            tick();
            for (int j = 0; j < ND; j++) if (digit_en[j] === 1'b0) seen[j] = display;
        end
    endtask

    initial begin
        logic [6:0] seen [ND];
        int r;
        int v;
        reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0;
        m_cnt = 0; since = 0; m_ovf = 1'b0;
        run(3);
        reset = 1'b0;
        run(20);

        do_load(1234, 1'b0, 1'b0);
        run(BW);
        capture(seen);
        chk("dec1234_d3", 32'(seen[3]), 32'(7'b1111001));
        chk("dec1234_d2", 32'(seen[2]), 32'(7'b0100100));
        chk("dec1234_d1", 32'(seen[1]), 32'(7'b0110000));
        chk("dec1234_d0", 32'(seen[0]), 32'(7'b0011001));

        do_load(7, 1'b0, 1'b1);
        run(BW + 17);
        do_load(7, 1'b0, 1'b0);
        run(BW + 17);

        do_load(32'h2AF, 1'b1, 1'b0);
        capture(seen);
        chk("hex2af_d3", 32'(seen[3]), 32'(7'b1000000));
        chk("hex2af_d2", 32'(seen[2]), 32'(7'b0100100));
        chk("hex2af_d1", 32'(seen[1]), 32'(7'b0001000));
        chk("hex2af_d0", 32'(seen[0]), 32'(7'b0001110));

        do_load(10000, 1'b0, 1'b0);
        run(BW + 17);
        chk("ovf_10000", 32'(overflow), 32'd1);
        do_load(42, 1'b0, 1'b1);
        run(BW + 17);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Load during busy is ignored
        do_load(1234, 1'b0, 1'b0);
        run(4);
        do_load(99, 1'b0, 1'b0);
        run(BW + 17);

        // Reset mid-conversion, with a simultaneous load
        do_load(4321, 1'b0, 1'b0);
        run(6);
        reset = 1'b1; value = BW'(55); load = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0;
        run(24);

        for (int it = 0; it < 600; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                case ($urandom_range(0, 5))
                    0: v = 0;
                    1: v = 9999;
                    2: v = 10000;
                    3: v = (1 << BW) - 1;
                    default: v = int'($urandom_range(0, (1 << BW) - 1));
                endcase
                do_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (r < 27) begin
                reset = 1'b1;
                load  = 1'($urandom_range(0, 1));
                tick();
                reset = 1'b0; load = 1'b0;
            end else begin
                tick();
            end
        end
        run(BW + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of seven-segment digits driven.
REQ-002 The block SHALL have parameter BIN_WIDTH, default 14: width of the binary input value.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit scan slot, minimum 2.
REQ-004 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port value, input, BIN_WIDTH: number to display, sampled on an accepted load.
REQ-007 The block SHALL have port load, input, 1: request to capture value and start a conversion.
REQ-008 The block SHALL have port hex_mode, input, 1: 1 = hexadecimal display, 0 = decimal; sampled with load.
REQ-009 The block SHALL have port blank_lz, input, 1: 1 = blank leading zeros; sampled with load.
REQ-010 The block SHALL have port display, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 The block SHALL have port digit_en, output, NUM_DIGITS: digit enables, active-low one-hot, registered.
REQ-012 The block SHALL have port busy, output, 1: high while a decimal conversion is in progress.
REQ-013 The block SHALL have port overflow, output, 1: high when the last loaded value does not fit in NUM_DIGITS digits.

Function
REQ-014 Load SHALL be accepted only when busy=0; a load while busy=1 SHALL be ignored, with no change to the capture or conversion.
REQ-015 Decimal mode SHALL convert sequentially by shift-add-3 (double-dabble), one bit per cycle.
REQ-016 In decimal mode, busy SHALL rise the cycle after an accepted load, stay high exactly BIN_WIDTH cycles, then fall in the same cycle the digit register updates.
REQ-017 Hex mode SHALL update the digit register with the value nibbles, least significant nibble at digit 0, on the cycle after load, with busy remaining 0.
REQ-018 Overflow SHALL be set when value exceeds 10^NUM_DIGITS-1 in decimal mode, or has a nonzero bit at or above 4*NUM_DIGITS in hex mode.
REQ-019 On overflow, every digit SHALL display a dash (0111111); overflow SHALL update together with the digit register and hold until the next completed load.
REQ-020 Decoding SHALL use active-low codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
REQ-021 With blank_lz=1, every zero digit above the most significant nonzero digit SHALL display blank; digit 0 is never blanked.
REQ-022 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the scan index SHALL advance by one, wrapping from NUM_DIGITS-1 to 0.
REQ-023 digit_en SHALL drive only the bit of the current scan index low, and display SHALL show that digit's code in the same cycle, with no skew between the two outputs.
REQ-024 Scanning SHALL run continuously and independently of load and busy; a mid-scan digit register update SHALL appear at the next output register update.
REQ-025 The display SHALL keep showing the previous digit register contents throughout a conversion.

Reset
REQ-026 While reset=1: display=1111111, digit_en=all ones, busy=0, overflow=0, digit register all blank, prescaler=0, scan index=0, any conversion aborted.
REQ-027 On the first cycle after reset deasserts, digit_en SHALL select digit 0, showing blank.
REQ-028 Reset SHALL take priority over load, including a load asserted in the same cycle.

Verification (NUM_DIGITS=4, BIN_WIDTH=14, SCAN_DIV=4)
REQ-029 The bench SHALL cover: reset, then idle -> digit_en cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clk; display=1111111 throughout.
REQ-030 The bench SHALL cover: load value=1234, hex_mode=0, blank_lz=0 -> busy high 14 cycles, then digits 3..0 show 1111001, 0100100, 0110000, 0011001; overflow=0.
REQ-031 The bench SHALL cover: load value=7, hex_mode=0, blank_lz=1 -> digits 3..1 show 1111111, digit 0 shows 1111000; with blank_lz=0 digits 3..1 show 1000000.
REQ-032 The bench SHALL cover: load value=0x2AF, hex_mode=1, blank_lz=0 -> busy stays 0; digits 3..0 show 1000000, 0100100, 0001000, 0001110 one cycle after load.
REQ-033 The bench SHALL cover: load value=10000, hex_mode=0 -> overflow=1 after conversion and all digits show 0111111; a following load of 42 clears overflow.
REQ-034 The bench SHALL cover: load 1234, then a second load of 99 at cycle 5 of busy -> second load ignored and result is 1234; reset at cycle 7 of a conversion -> all REQ-026 values next cycle.
